// File: rtl/spi_flash_responder.sv
// SPI (mode 0) serial-flash responder: READ 0x03, JEDEC ID 0x9F, STATUS 0x05.
// Optional FAST READ 0x0B with 8 dummy clocks when SPI_RESP_FASTREAD_EN is defined.
module spi_flash_responder #(
    parameter logic [23:0] JEDEC_ID   = 24'h202015,
    parameter logic [7:0]  STATUS_VAL = 8'h00
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        SCK,
    input  logic        CSB,
    input  logic        MOSI,
    output logic        MISO,
    output logic        MISO_OE,
    output logic [23:0] MEM_ADDR,
    output logic        MEM_RD,
    input  logic [7:0]  MEM_DATA
);
    typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, DATA, IGNORE} state_t;
    typedef enum logic [1:0] {SRC_READ, SRC_ID, SRC_STAT} src_t;

    logic [1:0]  sck_s, csb_s, mosi_s;
    logic        sck_d, csb_d, rst_done, armed;
    logic        sck_rise, sck_fall, csb_fall;
    state_t      state, nxt, dec_state;
    src_t        src, dec_src;
    logic        fast, dec_fast;
    logic [4:0]  bit_cnt;
    logic [23:0] sh_in;
    logic [7:0]  sh_out, cmd_byte, id_byte;
    logic [2:0]  out_cnt;
    logic [1:0]  id_idx;
    logic        miso_q, rd_d, cmd_done, addr_done, data_fall;

    // armed only after CSB has really been sampled high, so a CSB held low
    // across reset does not look like a fresh select
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            sck_s    <= 2'b00;
            csb_s    <= 2'b11;
            mosi_s   <= 2'b00;
            sck_d    <= 1'b0;
            csb_d    <= 1'b1;
            rst_done <= 1'b0;
            armed    <= 1'b0;
        end else begin
            sck_s    <= {sck_s[0], SCK};
            csb_s    <= {csb_s[0], CSB};
            mosi_s   <= {mosi_s[0], MOSI};
            sck_d    <= sck_s[1];
            csb_d    <= csb_s[1];
            rst_done <= 1'b1;
            armed    <= armed | (rst_done & csb_s[0]);
        end
    end

    assign sck_rise  = sck_s[1] & ~sck_d;
    assign sck_fall  = ~sck_s[1] & sck_d;
    assign csb_fall  = ~csb_s[1] & csb_d;
    assign cmd_byte  = {sh_in[6:0], mosi_s[1]};
    assign cmd_done  = (state == CMD) & ~csb_s[1] & sck_rise & (bit_cnt == 5'd7);
    assign addr_done = (state == ADDR) & ~csb_s[1] & sck_rise & (bit_cnt == 5'd23);
    assign data_fall = (state == DATA) & ~csb_s[1] & sck_fall;

    always_comb begin
        dec_state = IGNORE;
        dec_src   = SRC_READ;
        dec_fast  = 1'b0;
        case (cmd_byte)
            8'h03: dec_state = ADDR;
            8'h9F: begin dec_state = DATA; dec_src = SRC_ID;   end
            8'h05: begin dec_state = DATA; dec_src = SRC_STAT; end
`ifdef SPI_RESP_FASTREAD_EN
            8'h0B: begin dec_state = ADDR; dec_fast = 1'b1;   end
`endif
            default: ;
        endcase
    end

    always_comb begin
        case (id_idx)
            2'd0:    id_byte = JEDEC_ID[23:16];
            2'd1:    id_byte = JEDEC_ID[15:8];
            default: id_byte = JEDEC_ID[7:0];
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state <= IDLE;
        else       state <= nxt;
    end

    always_comb begin
        nxt = state;
        if (csb_s[1]) begin
            nxt = IDLE;
        end else begin
            case (state)
                IDLE:  if (csb_fall && armed) nxt = CMD;
                CMD:   if (cmd_done) nxt = dec_state;
                ADDR:  if (addr_done) nxt = fast ? DUMMY : DATA;
                DUMMY: if (sck_rise && bit_cnt == 5'd7) nxt = DATA;
                default: ;
            endcase
        end
    end

    always_comb begin
        MISO_OE = (state == DATA) & ~csb_s[1];
        MISO    = MISO_OE & miso_q;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            bit_cnt  <= '0;
            sh_in    <= '0;
            sh_out   <= '0;
            out_cnt  <= '0;
            id_idx   <= '0;
            src      <= SRC_READ;
            fast     <= 1'b0;
            miso_q   <= 1'b0;
            MEM_ADDR <= '0;
            MEM_RD   <= 1'b0;
            rd_d     <= 1'b0;
        end else begin
            MEM_RD <= 1'b0;
            rd_d   <= MEM_RD;
            if (rd_d) sh_out <= MEM_DATA;
            if (nxt != state)
                bit_cnt <= '0;
            else if (sck_rise && (state == CMD || state == ADDR || state == DUMMY))
                bit_cnt <= bit_cnt + 5'd1;
            if (sck_rise) sh_in <= {sh_in[22:0], mosi_s[1]};
            if (cmd_done) begin
                src    <= dec_src;
                fast   <= dec_fast;
                id_idx <= 2'd1;
                if (dec_src == SRC_ID)   sh_out <= JEDEC_ID[23:16];
                if (dec_src == SRC_STAT) sh_out <= STATUS_VAL;
            end
            if (addr_done) begin
                MEM_ADDR <= {sh_in[22:0], mosi_s[1]};
                MEM_RD   <= 1'b1;
            end
            // first data bit goes out on the fall following the last command/address rise
            if (data_fall) begin
                miso_q  <= sh_out[7];
                sh_out  <= {sh_out[6:0], 1'b0};
                out_cnt <= out_cnt + 3'd1;
                if (out_cnt == 3'd7) begin
                    case (src)
                        SRC_READ: begin
                            MEM_ADDR <= MEM_ADDR + 24'd1;
                            MEM_RD   <= 1'b1;
                        end
                        SRC_ID: begin
                            sh_out <= id_byte;
                            id_idx <= (id_idx == 2'd2) ? 2'd0 : id_idx + 2'd1;
                        end
                        default: sh_out <= STATUS_VAL;
                    endcase
                end
            end
            if (state != DATA) begin
                out_cnt <= '0;
                miso_q  <= 1'b0;
            end
        end
    end
endmodule
